// File: rtl/pipe_ctrl_pkg.sv
// Shared hold-flag encodings, bus-wait FSM states and small types used by the
// pipeline hold/flush controller and its bus-wait timer.
package pipe_ctrl_pkg;

  // Hold flag bus driven to pc_reg, if_id and id_ex.
  typedef logic [2:0] hold_flag_t;

  localparam hold_flag_t HOLD_NONE = 3'b000;  // pipeline runs freely
  localparam hold_flag_t HOLD_PC   = 3'b001;  // freeze PC
  localparam hold_flag_t HOLD_IF   = 3'b010;  // freeze PC + if_id, bubble into id_ex
  localparam hold_flag_t HOLD_ID   = 3'b011;  // freeze PC + if_id + id_ex

  // Bus-wait timer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_BUS_WAIT = 2'b01,
    ST_BUS_ERR  = 2'b10
  } bus_state_t;

  // Width needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the decode/execute/memory stages and pipe_ctrl.
//
// Handshake semantics: there is no ready/valid pair on the redirect path.
// jump_flag_o is a valid that the PC register always accepts in the same
// cycle, so jump_addr_o is only meaningful while jump_flag_o is 1 (and reads 0
// otherwise). mem_hold_req_i is an inverted ready from the data bus: while it
// is 1 the bus has not accepted/returned the access and the pipeline is held.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  logic        id_reg_we_i;
  logic [4:0]  id_reg_waddr_i;
  logic        id_is_load_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_hold_req_i;
  logic        mem_hold_req_i;

  hold_flag_t  hold_flag_o;
  logic        flush_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        bus_err_o;
  logic [31:0] stall_cnt_o;

  // Debug visibility of the bus-wait FSM and the load scoreboard.
  bus_state_t  dbg_state;
  logic        dbg_ld_valid;

  // Pipeline side: drives hazard/jump/hold requests, observes the results.
  modport master (
    output id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i,
           id_is_load_i, ex_jump_flag_i, ex_jump_addr_i, ex_hold_req_i,
           mem_hold_req_i,
    input  hold_flag_o, flush_o, jump_flag_o, jump_addr_o, bus_err_o,
           stall_cnt_o, dbg_state, dbg_ld_valid
  );

  // Controller side.
  modport slave (
    input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i,
           id_is_load_i, ex_jump_flag_i, ex_jump_addr_i, ex_hold_req_i,
           mem_hold_req_i,
    output hold_flag_o, flush_o, jump_flag_o, jump_addr_o, bus_err_o,
           stall_cnt_o, dbg_state, dbg_ld_valid
  );

endinterface

// File: rtl/pipe_ctrl_hold_timer.sv
// Bus-wait timer: tracks consecutive cycles of mem_hold_req, requests a
// pipeline hold for at most BUS_TIMEOUT cycles, then releases the hold and
// pulses bus_err for one cycle. Stays in BUS_ERR until the request drops.
module pipe_ctrl_hold_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_hold_req,
  output logic       bus_hold,
  output logic       bus_err,
  output bus_state_t state
);

  localparam int unsigned CW = cnt_width(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUS_TIMEOUT);

  bus_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;

  // State, wait counter and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bus_err <= err_nxt;
    end
  end

  // Next-state logic: cnt holds the number of hold cycles already spent.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_hold_req) begin
          state_nxt = ST_BUS_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      ST_BUS_WAIT: begin
        if (!mem_hold_req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_BUS_ERR;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_BUS_ERR: begin
        if (!mem_hold_req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: hold while waiting, released once the budget is used up.
  always_comb begin
    bus_hold = 1'b0;
    if (mem_hold_req) begin
      if (state == ST_IDLE) begin
        bus_hold = 1'b1;
      end else if (state == ST_BUS_WAIT && cnt != CNT_MAX) begin
        bus_hold = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller beside the decode stage: load-use hazard
// detection, jump redirect/flush, multi-cycle EX and bus-wait stretching,
// and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  hold_flag_t  hold_flag;
  logic        flush;
  logic        jump_flag;
  logic [31:0] jump_addr;

  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic        load_use;
  logic        ld_capture;

  logic        bus_hold;
  logic        bus_err;
  bus_state_t  bus_state;
  logic [31:0] stall_cnt;

  pipe_ctrl_hold_timer #(
    .BUS_TIMEOUT (BUS_TIMEOUT)
  ) u_hold_timer (
    .clk          (clk),
    .rst          (rst),
    .mem_hold_req (bus.mem_hold_req_i),
    .bus_hold     (bus_hold),
    .bus_err      (bus_err),
    .state        (bus_state)
  );

  // Load-use hazard: the load now in EX writes a register read by ID.
  always_comb begin
    load_use = ld_valid && (ld_rd != 5'd0) &&
               ((ld_rd == bus.id_reg1_raddr_i) || (ld_rd == bus.id_reg2_raddr_i));
  end

  // Priority mux: jump > EX busy > bus wait > load-use > none.
  always_comb begin
    hold_flag = HOLD_NONE;
    flush     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 32'h0;
    if (bus.ex_jump_flag_i) begin
      jump_flag = 1'b1;
      jump_addr = bus.ex_jump_addr_i;
      flush     = 1'b1;
    end else if (bus.ex_hold_req_i) begin
      hold_flag = HOLD_ID;
    end else if (bus_hold) begin
      hold_flag = HOLD_ID;
    end else if (load_use) begin
      hold_flag = HOLD_IF;
    end
  end

  // A load in ID moves to EX only when id_ex is not frozen or bubbled.
  always_comb begin
    ld_capture = bus.id_is_load_i && bus.id_reg_we_i && (bus.id_reg_waddr_i != 5'd0) &&
                 ((hold_flag == HOLD_NONE) || (hold_flag == HOLD_PC));
  end

  // Load scoreboard: a frozen id_ex keeps the load in EX, so the entry is
  // kept under Hold_Id; the Hold_If bubble or a flush retires it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid <= 1'b0;
      ld_rd    <= 5'd0;
    end else if (bus.ex_jump_flag_i || hold_flag == HOLD_IF) begin
      ld_valid <= 1'b0;
      ld_rd    <= 5'd0;
    end else if (hold_flag == HOLD_ID) begin
      ld_valid <= ld_valid;
      ld_rd    <= ld_rd;
    end else if (ld_capture) begin
      ld_valid <= 1'b1;
      ld_rd    <= bus.id_reg_waddr_i;
    end else begin
      ld_valid <= 1'b0;
      ld_rd    <= 5'd0;
    end
  end

  // Saturating count of held cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'h0;
    end else if (hold_flag != HOLD_NONE && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.hold_flag_o  = hold_flag;
  assign bus.flush_o      = flush;
  assign bus.jump_flag_o  = jump_flag;
  assign bus.jump_addr_o  = jump_addr;
  assign bus.bus_err_o    = bus_err;
  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.dbg_state    = bus_state;
  assign bus.dbg_ld_valid = ld_valid;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with BUS_TIMEOUT = 4.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_ctrl_if bus_if ();

  pipe_ctrl #(
    .BUS_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.id_reg1_raddr_i = 5'd0;
    bus_if.id_reg2_raddr_i = 5'd0;
    bus_if.id_reg_we_i     = 1'b0;
    bus_if.id_reg_waddr_i  = 5'd0;
    bus_if.id_is_load_i    = 1'b0;
    bus_if.ex_jump_flag_i  = 1'b0;
    bus_if.ex_jump_addr_i  = 32'h0;
    bus_if.ex_hold_req_i   = 1'b0;
    bus_if.mem_hold_req_i  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clear_inputs();
    bus_if.id_is_load_i   = 1'b1;
    bus_if.id_reg_we_i    = 1'b1;
    bus_if.id_reg_waddr_i = rd;
    bus_if.id_reg1_raddr_i = 5'd2;
  endtask

  task automatic drive_alu(input logic [4:0] rs1, input logic [4:0] rs2);
    clear_inputs();
    bus_if.id_reg_we_i     = 1'b1;
    bus_if.id_reg_waddr_i  = 5'd6;
    bus_if.id_reg1_raddr_i = rs1;
    bus_if.id_reg2_raddr_i = rs2;
  endtask

  // Reset state
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL rst_hold: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    checks++; if (bus_if.flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b exp 0", bus_if.flush_o); end
    checks++; if (bus_if.jump_flag_o !== 1'b0) begin errors++; $display("FAIL rst_jflag: got %b exp 0", bus_if.jump_flag_o); end
    checks++; if (bus_if.jump_addr_o !== 32'h0) begin errors++; $display("FAIL rst_jaddr: got %h exp 0", bus_if.jump_addr_o); end
    checks++; if (bus_if.bus_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", bus_if.bus_err_o); end
    checks++; if (bus_if.stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt: got %0d exp 0", bus_if.stall_cnt_o); end
    checks++; if (bus_if.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", bus_if.dbg_state, ST_IDLE); end
  endtask

  // Load-use stall, rs2 match, and x0 load never stalling
  task automatic test_load_use();
    do_reset();
    drive_load(5'd5);
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL lu_load_cycle: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    tick();
    drive_alu(5'd5, 5'd1);
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_IF) begin errors++; $display("FAIL lu_stall: got %0d exp %0d", bus_if.hold_flag_o, HOLD_IF); end
    tick();
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL lu_one_cycle: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    checks++; if (bus_if.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp 1", bus_if.stall_cnt_o); end
    tick();
    drive_load(5'd7);
    tick();
    drive_alu(5'd3, 5'd7);
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_IF) begin errors++; $display("FAIL lu_rs2: got %0d exp %0d", bus_if.hold_flag_o, HOLD_IF); end
    tick();
    drive_load(5'd0);
    tick();
    drive_alu(5'd0, 5'd1);
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL lu_x0: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    tick();
    #1;
    checks++; if (bus_if.stall_cnt_o !== 32'd2) begin errors++; $display("FAIL lu_x0_cnt: got %0d exp 2", bus_if.stall_cnt_o); end
    clear_inputs();
  endtask

  // Jump beats load-use and bus wait, and retires the pending load
  task automatic test_jump();
    do_reset();
    drive_load(5'd5);
    tick();
    drive_alu(5'd5, 5'd1);
    bus_if.ex_jump_flag_i = 1'b1;
    bus_if.ex_jump_addr_i = 32'h0000_0100;
    #1;
    checks++; if (bus_if.jump_flag_o !== 1'b1) begin errors++; $display("FAIL jmp_flag: got %b exp 1", bus_if.jump_flag_o); end
    checks++; if (bus_if.jump_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL jmp_addr: got %h exp 00000100", bus_if.jump_addr_o); end
    checks++; if (bus_if.flush_o !== 1'b1) begin errors++; $display("FAIL jmp_flush: got %b exp 1", bus_if.flush_o); end
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL jmp_hold: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    tick();
    bus_if.ex_jump_flag_i = 1'b0;
    bus_if.ex_jump_addr_i = 32'h0000_0100;
    #1;
    checks++; if (bus_if.dbg_ld_valid !== 1'b0) begin errors++; $display("FAIL jmp_ld_clear: got %b exp 0", bus_if.dbg_ld_valid); end
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL jmp_no_lu: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    checks++; if (bus_if.jump_addr_o !== 32'h0) begin errors++; $display("FAIL jmp_addr_zero: got %h exp 0", bus_if.jump_addr_o); end
    checks++; if (bus_if.flush_o !== 1'b0) begin errors++; $display("FAIL jmp_flush_off: got %b exp 0", bus_if.flush_o); end
    clear_inputs();
    tick();
    bus_if.mem_hold_req_i = 1'b1;
    tick();
    bus_if.ex_jump_flag_i = 1'b1;
    bus_if.ex_jump_addr_i = 32'h0000_0200;
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE || bus_if.flush_o !== 1'b1) begin errors++; $display("FAIL jmp_in_wait: hold %0d flush %b exp 0 1", bus_if.hold_flag_o, bus_if.flush_o); end
    tick();
    bus_if.ex_jump_flag_i = 1'b0;
    #1;
    checks++; if (bus_if.dbg_state !== ST_BUS_WAIT) begin errors++; $display("FAIL jmp_wait_state: got %0d exp %0d", bus_if.dbg_state, ST_BUS_WAIT); end
    checks++; if (bus_if.hold_flag_o !== HOLD_ID) begin errors++; $display("FAIL jmp_wait_hold: got %0d exp %0d", bus_if.hold_flag_o, HOLD_ID); end
    clear_inputs();
    tick();
  endtask

  // Short bus wait: 3 cycles, no error
  task automatic test_bus_wait();
    do_reset();
    bus_if.mem_hold_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus_if.hold_flag_o !== HOLD_ID) begin errors++; $display("FAIL bw_hold[%0d]: got %0d exp %0d", i, bus_if.hold_flag_o, HOLD_ID); end
      checks++; if (bus_if.bus_err_o !== 1'b0) begin errors++; $display("FAIL bw_err[%0d]: got %b exp 0", i, bus_if.bus_err_o); end
      tick();
    end
    bus_if.mem_hold_req_i = 1'b0;
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL bw_release: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    tick();
    #1;
    checks++; if (bus_if.dbg_state !== ST_IDLE) begin errors++; $display("FAIL bw_idle: got %0d exp %0d", bus_if.dbg_state, ST_IDLE); end
    checks++; if (bus_if.bus_err_o !== 1'b0) begin errors++; $display("FAIL bw_err_after: got %b exp 0", bus_if.bus_err_o); end
    checks++; if (bus_if.stall_cnt_o !== 32'd3) begin errors++; $display("FAIL bw_stall_cnt: got %0d exp 3", bus_if.stall_cnt_o); end
  endtask

  // Long bus wait: 4 hold cycles, timeout cycle, error pulse, no further hold
  task automatic test_timeout();
    hold_flag_t exp_hold;
    logic       exp_err;
    do_reset();
    bus_if.mem_hold_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_hold = (i < 4) ? HOLD_ID : HOLD_NONE;
      exp_err  = (i == 5);
      #1;
      checks++; if (bus_if.hold_flag_o !== exp_hold) begin errors++; $display("FAIL to_hold[%0d]: got %0d exp %0d", i, bus_if.hold_flag_o, exp_hold); end
      checks++; if (bus_if.bus_err_o !== exp_err) begin errors++; $display("FAIL to_err[%0d]: got %b exp %b", i, bus_if.bus_err_o, exp_err); end
      tick();
    end
    bus_if.mem_hold_req_i = 1'b0;
    #1;
    checks++; if (bus_if.dbg_state !== ST_BUS_ERR) begin errors++; $display("FAIL to_err_state: got %0d exp %0d", bus_if.dbg_state, ST_BUS_ERR); end
    checks++; if (bus_if.stall_cnt_o !== 32'd4) begin errors++; $display("FAIL to_stall_cnt: got %0d exp 4", bus_if.stall_cnt_o); end
    tick();
    bus_if.mem_hold_req_i = 1'b1;
    #1;
    checks++; if (bus_if.dbg_state !== ST_IDLE) begin errors++; $display("FAIL to_back_idle: got %0d exp %0d", bus_if.dbg_state, ST_IDLE); end
    checks++; if (bus_if.hold_flag_o !== HOLD_ID) begin errors++; $display("FAIL to_rehold: got %0d exp %0d", bus_if.hold_flag_o, HOLD_ID); end
    clear_inputs();
    tick();
  endtask

  // EX busy outranks load-use; load-use stall follows once EX frees up
  task automatic test_priority();
    do_reset();
    drive_load(5'd5);
    tick();
    drive_alu(5'd5, 5'd1);
    bus_if.ex_hold_req_i = 1'b1;
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_ID) begin errors++; $display("FAIL pri_ex_hold0: got %0d exp %0d", bus_if.hold_flag_o, HOLD_ID); end
    tick();
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_ID) begin errors++; $display("FAIL pri_ex_hold1: got %0d exp %0d", bus_if.hold_flag_o, HOLD_ID); end
    tick();
    bus_if.ex_hold_req_i = 1'b0;
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_IF) begin errors++; $display("FAIL pri_lu_after: got %0d exp %0d", bus_if.hold_flag_o, HOLD_IF); end
    tick();
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE) begin errors++; $display("FAIL pri_done: got %0d exp %0d", bus_if.hold_flag_o, HOLD_NONE); end
    checks++; if (bus_if.stall_cnt_o !== 32'd3) begin errors++; $display("FAIL pri_stall_cnt: got %0d exp 3", bus_if.stall_cnt_o); end
    clear_inputs();
    tick();
  endtask

  // Asynchronous reset in the middle of a bus wait and during the error pulse
  task automatic test_reset_mid_wait();
    do_reset();
    bus_if.mem_hold_req_i = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus_if.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmw_state: got %0d exp %0d", bus_if.dbg_state, ST_IDLE); end
    checks++; if (bus_if.stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rmw_stall_cnt: got %0d exp 0", bus_if.stall_cnt_o); end
    checks++; if (bus_if.bus_err_o !== 1'b0) begin errors++; $display("FAIL rmw_err: got %b exp 0", bus_if.bus_err_o); end
    clear_inputs();
    #1;
    checks++; if (bus_if.hold_flag_o !== HOLD_NONE || bus_if.flush_o !== 1'b0 || bus_if.jump_flag_o !== 1'b0 || bus_if.jump_addr_o !== 32'h0) begin
      errors++; $display("FAIL rmw_outputs: hold %0d flush %b jflag %b jaddr %h exp all 0", bus_if.hold_flag_o, bus_if.flush_o, bus_if.jump_flag_o, bus_if.jump_addr_o);
    end
    tick();
    rst = 1'b1;
    tick();
    bus_if.mem_hold_req_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    checks++; if (bus_if.bus_err_o !== 1'b1) begin errors++; $display("FAIL rmw_err_pulse: got %b exp 1", bus_if.bus_err_o); end
    rst = 1'b0;
    #1;
    checks++; if (bus_if.bus_err_o !== 1'b0) begin errors++; $display("FAIL rmw_err_reset: got %b exp 0", bus_if.bus_err_o); end
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Sequencer and final report
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_jump();
    test_bus_wait();
    test_timeout();
    test_priority();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
